mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage between EX and WB of the RV32I core.
- Issues loads and stores to the data-memory port over a req/gnt + rvalid handshake.
- Aligns store data and byte strobes; extracts and sign/zero-extends load data.
- Registers results into the MEM/WB boundary consumed by the writeback stage; stalls upstream while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- alu_result_in  in  XLEN  EX result; effective address for loads and stores.
- store_data_in  in  XLEN  rs2 value for stores.
- rd_in  in  5  destination register.
- valid_in  in  1  instruction in EX/MEM is valid.
- reg_write_in  in  1  instruction writes rd.
- wb_sel_in  in  2  writeback select, passed through (00 ALU, 01 mem, 10 PC+4).
- mem_read_in  in  1  load.
- mem_write_in  in  1  store.
- funct3_in  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- mem_stall  out  1  upstream must hold all inputs stable while high.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  word-aligned address (low two bits are 0).
- dmem_wdata  out  XLEN  lane-shifted store data.
- dmem_wstrb  out  4  byte enables.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load word.
- alu_result_out  out  XLEN  to WB.
- mem_data_out  out  XLEN  extended load data to WB.
- rd_out  out  5  to WB.
- valid_out  out  1  to WB.
- reg_write_out  out  1  to WB.
- wb_sel_out  out  2  to WB.
- misalign_out  out  1  one-cycle pulse with the faulting instruction.

Behaviour:
- Reset (rst=0 at clk edge):
  - All MEM/WB outputs go to 0; misalign_out=0.
  - FSM goes to IDLE, so dmem_req=0 and mem_stall=0.
  - Reset mid-transaction abandons the access with no output. The memory shares this reset.
- FSM states: IDLE, REQ, WAIT.
  - IDLE + valid memory op + aligned: dmem_req=1 combinationally in the same cycle.
    - gnt=1 on a store: complete.
    - gnt=1 on a load: go to WAIT.
    - gnt=0: go to REQ.
  - REQ: hold dmem_req and all dmem_* stable until gnt. Then a store completes and a load goes to WAIT.
  - WAIT: dmem_req=0. On rvalid, the load completes and the FSM returns to IDLE.
- Completion:
  - Output registers load on the clk edge at which the op completes; valid_out=1 the next cycle.
  - Minimum latency is 1 cycle: non-memory op, or a store granted immediately.
  - A load with immediate gnt and rvalid in the following cycle produces valid_out 2 cycles after entry.
  - rvalid in the same cycle as gnt is not permitted; the bench checks this never occurs.
- mem_stall = valid_in & (mem_read_in | mem_write_in) & aligned & ~completing_this_cycle.
- Every cycle without a completion loads valid_out=0 and reg_write_out=0 (bubble).
- Non-memory op: passes through registered in 1 cycle with no stall; mem_data_out=0.
- Store lanes, with off = addr[1:0]:
  - SB: wstrb = 0001<<off; wdata = byte replicated across all four lanes.
  - SH: wstrb = 0011<<off; wdata = halfword replicated in both halves.
  - SW: wstrb = 1111.
- Load extraction: select the byte or halfword at off, then sign-extend (LB, LH) or zero-extend (LBU, LHU). LW passes through.
- Misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0):
  - No dmem_req and no stall.
  - Registered next cycle: valid_out=1, reg_write_out=0, misalign_out=1.
- mem_read_in and mem_write_in both high: treated as a store.
- valid_in=0: no request, bubble output.

Test Plan:
- ALU op, addr 0x10, rd=5, reg_write=1 → next cycle valid_out=1, alu_result_out=0x10, rd_out=5; mem_stall never high.
- SB addr 0x1003, data 0xAB, gnt held low 2 cycles → dmem_req and mem_stall high 3 cycles; dmem_addr=0x1000, wstrb=1000, wdata=0xABABABAB; valid_out=1 after gnt.
- LB addr 0x2001, rdata 0x0000_8000 → mem_data_out=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- LH addr 0x2002, rdata 0x8001_0000 → 0xFFFF_8001. rvalid delayed 3 cycles → stall held through WAIT, one valid_out only.
- LW addr 0x2002 → no dmem_req; next cycle valid_out=1, reg_write_out=0, misalign_out=1 for exactly one cycle.
- rst=0 asserted during WAIT → next cycle all outputs 0 and FSM in IDLE. After release, an LW to 0x3000 completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave):
// a req/gnt request phase followed by an rvalid response phase for loads.
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [3:0]      dmem_wstrb;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory stage: issues aligned loads/stores, lane-shifts store data,
// extends load data and registers the MEM/WB boundary.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      rd_in,
  input  logic            valid_in,
  input  logic            reg_write_in,
  input  logic [1:0]      wb_sel_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic [2:0]      funct3_in,
  output logic            mem_stall,
  mem_stage_if.master     dmem,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] mem_data_out,
  output logic [4:0]      rd_out,
  output logic            valid_out,
  output logic            reg_write_out,
  output logic [1:0]      wb_sel_out,
  output logic            misalign_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_next;
  logic [1:0]  off;
  logic        mem_op, is_store, is_load, aligned, misalign;
  logic        req, complete;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [XLEN-1:0] load_ext;

  assign off      = alu_result_in[1:0];
  assign mem_op   = valid_in & (mem_read_in | mem_write_in);
  // A simultaneous read+write request is handled as a store.
  assign is_store = mem_write_in;
  assign is_load  = mem_read_in & ~mem_write_in;
  assign misalign = mem_op & ~aligned;

  always_comb begin
    case (funct3_in[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      default: aligned = (off == 2'b00);
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && aligned) begin
          req = 1'b1;
          if (dmem.dmem_gnt) begin
            if (is_store) complete   = 1'b1;
            else          state_next = WAIT;
          end else begin
            state_next = REQ;
          end
        end else begin
          // Non-memory ops and misaligned faults retire without touching memory.
          complete = valid_in;
        end
      end
      REQ: begin
        req = 1'b1;
        if (dmem.dmem_gnt) begin
          if (is_store) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_stall     = mem_op & aligned & ~complete;
  assign dmem.dmem_req = req;
  assign dmem.dmem_we  = is_store;
  assign dmem.dmem_addr = {alu_result_in[XLEN-1:2], 2'b00};

  always_comb begin
    case (funct3_in[1:0])
      2'b00: begin
        dmem.dmem_wdata = {4{store_data_in[7:0]}};
        dmem.dmem_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        dmem.dmem_wdata = {2{store_data_in[15:0]}};
        dmem.dmem_wstrb = 4'b0011 << off;
      end
      default: begin
        dmem.dmem_wdata = store_data_in;
        dmem.dmem_wstrb = 4'b1111;
      end
    endcase
  end

  assign ld_byte = dmem.dmem_rdata[{off, 3'b000} +: 8];
  assign ld_half = dmem.dmem_rdata[{off[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3_in)
      3'b000:  load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
      default: load_ext = dmem.dmem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_result_out <= '0;
      mem_data_out   <= '0;
      rd_out         <= '0;
      valid_out      <= 1'b0;
      reg_write_out  <= 1'b0;
      wb_sel_out     <= '0;
      misalign_out   <= 1'b0;
    end else begin
      valid_out     <= complete;
      reg_write_out <= complete & reg_write_in & ~misalign;
      misalign_out  <= complete & misalign;
      if (complete) begin
        alu_result_out <= alu_result_in;
        rd_out         <= rd_in;
        wb_sel_out     <= wb_sel_in;
        mem_data_out   <= (is_load & mem_op & ~misalign) ? load_ext : '0;
      end
    end
  end

endmodule
